sum_splitter_seq: RTL and testbench

- Sequential inverse of the parallel adder tree: takes one accumulated total and splits it into TREE_SIZE equal packed lanes.
- Uses a bit-serial restoring divider (total / TREE_SIZE), then fills the lanes.
- Sits downstream of reduction logic, for example to redistribute a budget or average back across lanes.
- Valid/ready handshake on both sides; one division in flight at a time.

---
 rtl/sum_split_pkg.sv | 20 ++
 rtl/restoring_div_step.sv | 21 ++
 rtl/sum_splitter_seq.sv | 145 ++++++++++++++
 tb/tb_sum_splitter_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sum_split_pkg.sv
// Shared types and width helpers for the sum splitter.
// Widths are derived from TREE_SIZE and DATA_SIZE so every user agrees on them.
package sum_split_pkg;

   typedef enum logic [1:0] {IDLE, DIV, HOLD} state_t;

   function automatic int calc_zw(input int tree_size, input int data_size);
      return data_size + $clog2(tree_size) + 1;
   endfunction

   function automatic int calc_lw(input int data_size);
      return data_size + 1;
   endfunction

   // The remainder stays below tree_size, so one extra bit holds the shifted trial value.
   function automatic int calc_rw(input int tree_size);
      return $clog2(tree_size) + 1;
   endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One combinational restoring-division step by a constant divisor.
// Shifts the next dividend bit into the remainder and conditionally subtracts.
module restoring_div_step #(
   parameter int DIVISOR = 4,
   parameter int RW      = 3
) (
   input  logic [RW-1:0] rem_i,
   input  logic          bit_i,
   output logic [RW-1:0] rem_o,
   output logic          qbit_o
);

   logic [RW:0] trial;

   always_comb begin
      trial  = {rem_i, bit_i};
      qbit_o = (trial >= (RW+1)'(DIVISOR));
      rem_o  = qbit_o ? RW'(trial - (RW+1)'(DIVISOR)) : RW'(trial);
   end

endmodule

// File: rtl/sum_splitter_seq.sv
// Splits one accumulated total into TREE_SIZE equal lanes via a bit-serial divider.
// Define SUM_SPLIT_REM_EN to spread the remainder over the low lanes instead of flooring.
module sum_splitter_seq
   import sum_split_pkg::*;
#(
   parameter int  TREE_SIZE = 4,
   parameter int  DATA_SIZE = 8,
   localparam int ZW        = calc_zw(TREE_SIZE, DATA_SIZE),
   localparam int LW        = calc_lw(DATA_SIZE)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [ZW-1:0]           Z,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [TREE_SIZE*LW-1:0] S,
   output logic                    ovf
);

   localparam int RW = calc_rw(TREE_SIZE);
   localparam int CW = (ZW > 1) ? $clog2(ZW) : 1;

   state_t                  state_q, state_d;
   logic [ZW-1:0]           dvd_q, dvd_d;
   logic [RW-1:0]           rem_q, rem_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    last_q, last_d;
   logic                    in_ready_q, in_ready_d;
   logic                    out_valid_q, out_valid_d;
   logic [TREE_SIZE*LW-1:0] s_q, s_d;
   logic                    ovf_q, ovf_d;

   logic [RW-1:0]           step_rem;
   logic                    step_qbit;
   logic                    fill_ovf;
   logic [LW-1:0]           fill_base;
   logic [TREE_SIZE*LW-1:0] fill_s;

   restoring_div_step #(
      .DIVISOR (TREE_SIZE),
      .RW      (RW)
   ) u_step (
      .rem_i  (rem_q),
      .bit_i  (dvd_q[ZW-1]),
      .rem_o  (step_rem),
      .qbit_o (step_qbit)
   );

   // Quotient bits shift into the dividend register, so it holds q once the steps finish.
   always_comb begin
      fill_ovf  = |dvd_q[ZW-1:LW];
      fill_base = fill_ovf ? '1 : dvd_q[LW-1:0];
      fill_s    = '0;
      for (int j = 0; j < TREE_SIZE; j++) begin
`ifdef SUM_SPLIT_REM_EN
         // An unsaturated base of all ones cannot take +1 without wrapping, so it clamps.
         if (!fill_ovf && (RW'(j) < rem_q) && !(&fill_base))
            fill_s[j*LW +: LW] = fill_base + LW'(1);
         else
            fill_s[j*LW +: LW] = fill_base;
`else
         fill_s[j*LW +: LW] = fill_base;
`endif
      end
   end

   // NOTE: every *_d gets a default first, so no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      dvd_d       = dvd_q;
      rem_d       = rem_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      s_d         = s_q;
      ovf_d       = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               dvd_d      = Z;
               rem_d      = '0;
               cnt_d      = CW'(ZW - 1);
               last_d     = 1'b0;
               in_ready_d = 1'b0;
               state_d    = DIV;
            end
         end
         DIV: begin
            if (!last_q) begin
               dvd_d = {dvd_q[ZW-2:0], step_qbit};
               rem_d = step_rem;
               if (cnt_q == '0) last_d = 1'b1;
               else             cnt_d  = cnt_q - CW'(1);
            end else begin
               s_d         = fill_s;
               ovf_d       = fill_ovf;
               out_valid_d = 1'b1;
               state_d     = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         dvd_q       <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         last_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         s_q         <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         dvd_q       <= dvd_d;
         rem_q       <= rem_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         s_q         <= s_d;
         ovf_q       <= ovf_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign S         = s_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_sum_splitter_seq.sv
// Self-checking bench: a 4-lane and a 3-lane splitter against an arithmetic divide model.
// Honors SUM_SPLIT_REM_EN the same way as the design build.
module tb_sum_splitter_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid_a [2];
   logic        out_ready_a[2];
   logic [10:0] z_a        [2];

   logic        in_ready4, out_valid4, ovf4;
   logic        in_ready3, out_valid3, ovf3;
   logic [35:0] s4;
   logic [26:0] s3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sum_splitter_seq #(.TREE_SIZE(4), .DATA_SIZE(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[0]), .in_ready(in_ready4), .Z(z_a[0]),
      .out_valid(out_valid4), .out_ready(out_ready_a[0]), .S(s4), .ovf(ovf4)
   );

   sum_splitter_seq #(.TREE_SIZE(3), .DATA_SIZE(8)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[1]), .in_ready(in_ready3), .Z(z_a[1]),
      .out_valid(out_valid3), .out_ready(out_ready_a[1]), .S(s3), .ovf(ovf3)
   );

   function automatic logic [35:0] get_s(input int k);
      return (k != 0) ? {9'd0, s3} : s4;
   endfunction

   // Expected lanes from plain integer division by the lane count.
   function automatic void model(input int t, input int z, output logic [35:0] s, output bit o);
      int q, base, lane;
      q    = z / t;
      o    = (q > 511);
      base = o ? 511 : q;
      s    = '0;
      for (int j = 0; j < t; j++) begin
         lane = base;
`ifdef SUM_SPLIT_REM_EN
         if (!o && j < (z % t)) lane = (base + 1 > 511) ? 511 : base + 1;
`endif
         s[j*9 +: 9] = lane[8:0];
      end
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input int k, input logic [10:0] z);
      int n = 0;
      @(negedge clk);
      in_valid_a[k] = 1'b1;
      z_a[k]        = z;
      while (!((k != 0) ? in_ready3 : in_ready4) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept_bound", 64'(n < 50), 64'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid_a[k] = 1'b0;
   endtask

   task automatic collect(input int k, input logic [10:0] z, input int hold_n, input bit offer);
      int          n = 0;
      logic [35:0] es;
      bit          eo;
      model((k != 0) ? 3 : 4, int'(z), es, eo);
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!((k != 0) ? out_valid3 : out_valid4) && n < 100);
      check("latency", 64'(n), 64'd12);
      check("lanes", get_s(k), es);
      check("ovf", 64'((k != 0) ? ovf3 : ovf4), 64'(eo));
      for (int c = 0; c < hold_n; c++) begin
         @(negedge clk);
         if (offer) begin
            in_valid_a[k] = 1'b1;
            z_a[k]        = 11'd7;
         end
         @(posedge clk);
         #1;
         check("hold_lanes", get_s(k), es);
         check("hold_valid", 64'((k != 0) ? out_valid3 : out_valid4), 64'd1);
         check("hold_in_ready", 64'((k != 0) ? in_ready3 : in_ready4), 64'd0);
      end
      @(negedge clk);
      out_ready_a[k] = 1'b1;
      @(posedge clk);
      #1;
      check("hs_valid", 64'((k != 0) ? out_valid3 : out_valid4), 64'd0);
      check("hs_in_ready", 64'((k != 0) ? in_ready3 : in_ready4), 64'd1);
      @(negedge clk);
      out_ready_a[k] = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          saw;
      int          k;
      logic [10:0] z;

      for (int i = 0; i < 2; i++) begin
         in_valid_a[i]  = 1'b0;
         out_ready_a[i] = 1'b0;
         z_a[i]         = '0;
      end
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready4), 64'd1);
      check("rst_out_valid", 64'(out_valid4), 64'd0);
      check("rst_lanes", 64'(s4), 64'd0);
      check("rst_ovf", 64'(ovf4), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Full-scale total with the consumer always ready.
      out_ready_a[0] = 1'b1;
      send(0, 11'd1023);
      collect(0, 11'd1023, 0, 1'b0);

      send(0, 11'd0);
      collect(0, 11'd0, 0, 1'b0);

      // Three lanes: saturation and remainder spreading.
      send(1, 11'd2047);
      collect(1, 11'd2047, 0, 1'b0);
      send(1, 11'd10);
      collect(1, 11'd10, 0, 1'b0);

      // Backpressure in HOLD with a new total offered; it is taken only after the handshake.
      send(0, 11'd100);
      collect(0, 11'd100, 5, 1'b1);
      @(posedge clk);
      @(negedge clk);
      in_valid_a[0] = 1'b0;
      collect(0, 11'd7, 0, 1'b0);

      send(0, 11'd2047);
      collect(0, 11'd2047, 0, 1'b0);

      // Reset in the fifth DIV cycle abandons the division.
      send(0, 11'd1500);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_out_valid", 64'(out_valid4), 64'd0);
      check("mid_rst_lanes", 64'(s4), 64'd0);
      check("mid_rst_in_ready", 64'(in_ready4), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      saw   = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (out_valid4) saw = 1'b1;
      end
      check("no_stale_output", 64'(saw), 64'd0);

      for (int i = 0; i < 16; i++) begin
         k = i % 2;
         z = 11'($urandom_range(2047, 0));
         send(k, z);
         collect(k, z, 0, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
